// File: rtl/trafficlight_pkg.sv
// Shared light encodings, fault codes and light-rule helpers for the traffic light monitor.
package trafficlight_pkg;

    typedef logic [2:0] light_t;
    typedef logic [2:0] fcode_t;

    localparam light_t LIGHT_GREEN  = 3'b001;
    localparam light_t LIGHT_YELLOW = 3'b010;
    localparam light_t LIGHT_RED    = 3'b100;

    localparam fcode_t FC_NONE     = 3'd0;
    localparam fcode_t FC_ENC      = 3'd1;
    localparam fcode_t FC_CONFLICT = 3'd2;
    localparam fcode_t FC_SEQ      = 3'd3;
    localparam fcode_t FC_YELLOW   = 3'd4;
    localparam fcode_t FC_ALLRED   = 3'd5;

    function automatic logic light_valid(light_t l);
        return (l == LIGHT_GREEN) || (l == LIGHT_YELLOW) || (l == LIGHT_RED);
    endfunction

    // Holding the same colour is always legal; otherwise only G->Y, Y->R, R->G.
    function automatic logic legal_step(light_t prev, light_t cur);
        return (cur == prev)
            || ((prev == LIGHT_GREEN)  && (cur == LIGHT_YELLOW))
            || ((prev == LIGHT_YELLOW) && (cur == LIGHT_RED))
            || ((prev == LIGHT_RED)    && (cur == LIGHT_GREEN));
    endfunction

endpackage

// File: rtl/trafficlight_monitor_light_dwell_timer.sv
// Per-direction history: previous light, saturating dwell counter and transition legality.
module light_dwell_timer
    import trafficlight_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] light_i,
    output logic       trans_legal_o,
    output logic       over_limit_o
);

    localparam int             CW  = $clog2(LIMIT + 2);
    localparam logic [CW-1:0]  SAT = CW'(LIMIT + 1);
    localparam logic [CW-1:0]  LIM = CW'(LIMIT);

    logic [2:0]    prev_q;
    logic [CW-1:0] dwell_q;
    logic [CW-1:0] dwell_d;

    // dwell_d counts the current sample too, so the check fires on sample LIMIT+1.
    always_comb begin
        dwell_d = CW'(1);
        if (light_i == prev_q) begin
            dwell_d = (dwell_q == SAT) ? SAT : dwell_q + 1'b1;
        end
    end

    assign trans_legal_o = legal_step(prev_q, light_i);
    assign over_limit_o  = (dwell_d > LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 3'b000;
            dwell_q <= '0;
        end else begin
            prev_q  <= light_i;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/trafficlight_monitor.sv
// Checks controller light outputs each cycle and latches the first fault until cleared.
module trafficlight_monitor
    import trafficlight_pkg::*;
#(
    parameter int YELLOW_MAX = 4,
    parameter int ALLRED_MAX = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       ns_light,
    input  logic [2:0]       ew_light,
    input  logic             emgcy_sensor,
    input  logic             clr_fault,
    output logic             viol,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic             force_red,
    output logic [CNT_W-1:0] fault_cnt
);

    localparam int            AW   = $clog2(ALLRED_MAX + 2);
    localparam logic [AW-1:0] ASAT = AW'(ALLRED_MAX + 1);
    localparam logic [AW-1:0] ALIM = AW'(ALLRED_MAX);

    logic ns_legal, ew_legal, ns_over, ew_over;

    light_dwell_timer #(.LIMIT(YELLOW_MAX)) u_ns_timer (
        .clk          (clk),
        .reset        (reset),
        .light_i      (ns_light),
        .trans_legal_o(ns_legal),
        .over_limit_o (ns_over)
    );

    light_dwell_timer #(.LIMIT(YELLOW_MAX)) u_ew_timer (
        .clk          (clk),
        .reset        (reset),
        .light_i      (ew_light),
        .trans_legal_o(ew_legal),
        .over_limit_o (ew_over)
    );

    logic             prev_valid_q, prev_enc_bad_q;
    logic [AW-1:0]    allred_q, allred_d;
    logic             viol_q, viol_d;
    logic             fault_q, fault_d;
    fcode_t           code_q, code_d, code_now;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enc_bad, both_red;

    always_comb begin
        enc_bad  = !(light_valid(ns_light) && light_valid(ew_light));
        both_red = (ns_light == LIGHT_RED) && (ew_light == LIGHT_RED);

        allred_d = '0;
        if (!emgcy_sensor && both_red) begin
            allred_d = (allred_q == ASAT) ? ASAT : allred_q + 1'b1;
        end

        // A sample after an invalid encoding has no trustworthy history for SEQ.
        code_now = FC_NONE;
        if (enc_bad) begin
            code_now = FC_ENC;
        end else if ((ns_light != LIGHT_RED) && (ew_light != LIGHT_RED)) begin
            code_now = FC_CONFLICT;
        end else if (prev_valid_q && !prev_enc_bad_q && !(ns_legal && ew_legal)) begin
            code_now = FC_SEQ;
        end else if (((ns_light == LIGHT_YELLOW) && ns_over) ||
                     ((ew_light == LIGHT_YELLOW) && ew_over)) begin
            code_now = FC_YELLOW;
        end else if (allred_d > ALIM) begin
            code_now = FC_ALLRED;
        end
        viol_d = (code_now != FC_NONE);

        fault_d = fault_q;
        code_d  = code_q;
        if (clr_fault) begin
            fault_d = viol_d;
            code_d  = viol_d ? code_now : FC_NONE;
        end else if (!fault_q && viol_d) begin
            fault_d = 1'b1;
            code_d  = code_now;
        end

        cnt_d = cnt_q;
        if (viol_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_valid_q   <= 1'b0;
            prev_enc_bad_q <= 1'b0;
            allred_q       <= '0;
            viol_q         <= 1'b0;
            fault_q        <= 1'b0;
            code_q         <= FC_NONE;
            cnt_q          <= '0;
        end else begin
            prev_valid_q   <= 1'b1;
            prev_enc_bad_q <= enc_bad;
            allred_q       <= allred_d;
            viol_q         <= viol_d;
            fault_q        <= fault_d;
            code_q         <= code_d;
            cnt_q          <= cnt_d;
        end
    end

    assign viol       = viol_q;
    assign fault      = fault_q;
    assign force_red  = fault_q;
    assign fault_code = code_q;
    assign fault_cnt  = cnt_q;

endmodule

// File: doc/trafficlight_monitor.md
TRAFFICLIGHT_MONITOR -- requirements
Module: trafficlight_monitor

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter YELLOW_MAX, default 4: maximum legal consecutive yellow cycles per direction.
REQ-003 Parameter ALLRED_MAX, default 8: maximum legal consecutive cycles with both directions red while emgcy_sensor=0.
REQ-004 Parameter CNT_W, default 8: width of fault_cnt.
REQ-005 Port clk, input, 1: rising-edge clock for all state.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Port ns_light, input, 3: north-south light as driven by the controller.
REQ-008 Port ew_light, input, 3: east-west light as driven by the controller.
REQ-009 Port emgcy_sensor, input, 1: emergency request; all-red is legal indefinitely while it is high.
REQ-010 Port clr_fault, input, 1: single-cycle pulse that clears the latched fault.
REQ-011 Port viol, output, 1: registered; high for each cycle in which any check fails.
REQ-012 Port fault, output, 1: latched sticky fault flag.
REQ-013 Port fault_code, output, 3: code of the first violation since the last clear.
REQ-014 Port force_red, output, 1: equals fault; the top level uses it to override both lights to red.
REQ-015 Port fault_cnt, output, CNT_W: saturating count of cycles with viol=1.

Function
REQ-016 Light encoding SHALL be one-hot: GREEN=3'b001, YELLOW=3'b010, RED=3'b100.
REQ-017 Inputs SHALL be evaluated at each rising edge, and results SHALL be visible on registered outputs immediately after that edge (1-cycle latency).
REQ-018 ENC check: either light is not exactly one-hot -> code 3'd1.
REQ-019 CONFLICT check: neither light is RED -> code 3'd2.
REQ-020 SEQ check: a per-direction change other than G->Y, Y->R or R->G -> code 3'd3.
REQ-021 The SEQ check SHALL be skipped on the first sample after reset (prev_valid=0) and whenever the previous sample failed ENC.
REQ-022 YELLOW check: a direction's yellow dwell counter exceeds YELLOW_MAX -> code 3'd4, on the (YELLOW_MAX+1)th consecutive yellow sample.
REQ-023 ALLRED check: both directions RED, emgcy_sensor=0, and the all-red counter exceeds ALLRED_MAX -> code 3'd5.
REQ-024 The all-red counter SHALL reset to 0 while emgcy_sensor=1.
REQ-025 Priority for simultaneous violations SHALL be ENC > CONFLICT > SEQ > YELLOW > ALLRED; code 3'd0 means no fault.
REQ-026 Dwell counters SHALL saturate at their limit+1 and restart at 1 on a colour change; the YELLOW and ALLRED checks SHALL repeat viol every cycle while the condition persists.
REQ-027 On the first violation while fault=0, fault SHALL be set and fault_code loaded; later violations SHALL NOT overwrite fault_code.
REQ-028 clr_fault SHALL clear fault and fault_code at the next edge.
REQ-029 If clr_fault coincides with a violation, the new violation SHALL be latched (set wins).
REQ-030 fault_cnt SHALL increment on every viol cycle, hold at all ones, and SHALL NOT be cleared by clr_fault.

Reset
REQ-031 With reset=1 at an edge, the following SHALL all be 0 after that edge: viol, fault, fault_code, force_red, fault_cnt, prev_valid, all dwell counters and previous-light registers.
REQ-032 Reset SHALL override clr_fault and any concurrent violation.
REQ-033 Reset asserted mid-dwell SHALL discard the dwell history, with no residual viol.

Structure
REQ-034 Package trafficlight_pkg SHALL hold the light encodings, the fault code constants and the light type.
REQ-035 Sub-module light_dwell_timer SHALL be instantiated once per direction.
REQ-036 light_dwell_timer SHALL provide a previous-light register, a saturating dwell counter and the transition-legal flag.
REQ-037 All outputs SHALL be flop-driven.

Verification
REQ-038 Legal cycle: ns G(3)/Y(2)/R with ew R, then mirrored -> viol=0 and fault_cnt=0 throughout.
REQ-039 Conflict: ns=001 and ew=001 for 1 cycle -> viol=1 and fault=1 next edge, fault_code=2, fault_cnt=1; force_red stays 1 after the lights recover.
REQ-040 Skip yellow: ns 001 -> 100 -> fault_code=3.
REQ-041 Simultaneous violations: ew=011 together with ns=001 -> fault_code=1 (ENC wins).
REQ-042 Yellow timeout: ns yellow held 6 cycles -> viol on samples 5 and 6, fault_code=4, fault_cnt=2.
REQ-043 All-red: 10 cycles with emgcy_sensor=0 -> viol on samples 9 and 10, fault_code=5; the same 10 cycles with emgcy_sensor=1 -> viol=0.
REQ-044 Clear versus fault: clr_fault in the same cycle as a conflict -> fault stays 1, fault_code=2.
REQ-045 Reset: reset mid-yellow -> all outputs 0 next edge, and the first sample after reset raises no SEQ violation.
